// File: rtl/hash_arbiter_if.sv
// Hash-core side bundle of the hash arbiter. The master modport is the
// arbiter, the slave modport is the hash memory interface it feeds.
interface hash_arbiter_if #(
  parameter int IO_WIDTH   = 32,
  parameter int ADDR_WIDTH = 10
);
  logic                  o_hash_start;
  logic [31:0]           o_hash_input_length;
  logic [31:0]           o_hash_output_length;
  logic [IO_WIDTH-1:0]   o_hash_data_in;
  logic                  o_hash_data_out_ready;
  logic                  o_hash_force_done;
  logic [ADDR_WIDTH-1:0] i_hash_addr;
  logic                  i_hash_rd_en;
  logic [IO_WIDTH-1:0]   i_hash_data_out;
  logic                  i_hash_data_out_valid;
  logic                  i_hash_force_done_ack;

  modport master (
    output o_hash_start, o_hash_input_length, o_hash_output_length,
           o_hash_data_in, o_hash_data_out_ready, o_hash_force_done,
    input  i_hash_addr, i_hash_rd_en, i_hash_data_out,
           i_hash_data_out_valid, i_hash_force_done_ack
  );

  modport slave (
    input  o_hash_start, o_hash_input_length, o_hash_output_length,
           o_hash_data_in, o_hash_data_out_ready, o_hash_force_done,
    output i_hash_addr, i_hash_rd_en, i_hash_data_out,
           i_hash_data_out_valid, i_hash_force_done_ack
  );
endinterface

// File: rtl/hash_arbiter.sv
// Round-robin arbiter sharing one hash core among NUM_REQ requesters.
// One job at a time: IDLE picks a winner, START fires the core for one
// cycle, BUSY routes the winner's data until force_done is acknowledged.
module hash_arbiter #(
  parameter int NUM_REQ    = 3,
  parameter int IO_WIDTH   = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic [NUM_REQ-1:0]          i_req,
  input  logic [NUM_REQ*32-1:0]       i_req_input_length,
  input  logic [NUM_REQ*32-1:0]       i_req_output_length,
  input  logic [NUM_REQ*IO_WIDTH-1:0] i_req_data_in,
  input  logic [NUM_REQ-1:0]          i_req_data_out_ready,
  input  logic [NUM_REQ-1:0]          i_req_force_done,
  output logic [NUM_REQ-1:0]          o_gnt,
  output logic [ADDR_WIDTH-1:0]       o_req_addr,
  output logic [NUM_REQ-1:0]          o_req_rd_en,
  output logic [IO_WIDTH-1:0]         o_req_data_out,
  output logic [NUM_REQ-1:0]          o_req_data_out_valid,
  output logic [NUM_REQ-1:0]          o_req_done,
  hash_arbiter_if.master              hash
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_BUSY  = 2'd2
  } state_t;

  state_t              state_r, state_nxt_s;
  logic [NUM_REQ-1:0]  gnt_r;
  logic [IDX_W-1:0]    gnt_idx_r;
  logic [IDX_W-1:0]    last_gnt_r;
  logic [31:0]         in_len_r, out_len_r;
  logic                start_r;
  logic [NUM_REQ-1:0]  done_r;
  logic [IDX_W:0]      pick_s;
  logic                win_found_s;
  logic [IDX_W-1:0]    win_idx_s;
  logic [NUM_REQ-1:0]  win_onehot_s;
  logic [IO_WIDTH-1:0] data_in_s;
  logic                data_out_ready_s;
  logic                force_done_s;
  logic                finish_s;

  // Round-robin pick: nearest requester above 'last' (wrapping) wins.
  // Scans from the farthest candidate down so the nearest one overwrites.
  function automatic logic [IDX_W:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                              input logic [IDX_W-1:0]   last);
    logic [IDX_W:0]   res;
    logic [IDX_W-1:0] cand_idx;
    int               cand;
    res = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand = int'(last) + 1 + i;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      else                 cand = cand;
      cand_idx = cand[IDX_W-1:0];
      if (req[cand_idx]) res = {1'b1, cand_idx};
      else               res = res;
    end
    return res;
  endfunction

  assign pick_s       = rr_pick(i_req, last_gnt_r);
  assign win_found_s  = pick_s[IDX_W];
  assign win_idx_s    = pick_s[IDX_W-1:0];
  assign win_onehot_s = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_idx_s;
  assign finish_s     = (state_r == ST_BUSY) & force_done_s & hash.i_hash_force_done_ack;

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) state_r <= ST_IDLE;
    else       state_r <= state_nxt_s;
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (win_found_s) state_nxt_s = ST_START;
        else             state_nxt_s = ST_IDLE;
      end
      ST_START: state_nxt_s = ST_BUSY;
      ST_BUSY: begin
        if (finish_s) state_nxt_s = ST_IDLE;
        else          state_nxt_s = ST_BUSY;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Per-state routing of the granted requester to the hash core.
  always_comb begin
    data_in_s        = '0;
    data_out_ready_s = 1'b0;
    force_done_s     = 1'b0;
    case (state_r)
      ST_START: data_in_s = i_req_data_in[int'(gnt_idx_r)*IO_WIDTH +: IO_WIDTH];
      ST_BUSY: begin
        data_in_s        = i_req_data_in[int'(gnt_idx_r)*IO_WIDTH +: IO_WIDTH];
        data_out_ready_s = i_req_data_out_ready[gnt_idx_r];
        force_done_s     = i_req_force_done[gnt_idx_r];
      end
      default: begin
        data_in_s        = '0;
        data_out_ready_s = 1'b0;
        force_done_s     = 1'b0;
      end
    endcase
  end

  // Grant, latched lengths, start/done pulses and round-robin pointer.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      gnt_r      <= '0;
      gnt_idx_r  <= '0;
      last_gnt_r <= IDX_W'(NUM_REQ - 1);
      in_len_r   <= 32'd0;
      out_len_r  <= 32'd0;
      start_r    <= 1'b0;
      done_r     <= '0;
    end else begin
      start_r <= (state_r == ST_IDLE) && win_found_s;
      if (finish_s) done_r <= gnt_r;
      else          done_r <= '0;
      case (state_r)
        ST_IDLE: begin
          if (win_found_s) begin
            gnt_r     <= win_onehot_s;
            gnt_idx_r <= win_idx_s;
            in_len_r  <= i_req_input_length[32*int'(win_idx_s) +: 32];
            out_len_r <= i_req_output_length[32*int'(win_idx_s) +: 32];
          end else begin
            gnt_r <= '0;
          end
        end
        ST_START: last_gnt_r <= gnt_idx_r;
        ST_BUSY: begin
          if (finish_s) gnt_r <= '0;
          else          gnt_r <= gnt_r;
        end
        default: gnt_r <= '0;
      endcase
    end
  end

  assign o_gnt                      = gnt_r;
  assign o_req_done                 = done_r;
  assign o_req_addr                 = hash.i_hash_addr;
  assign o_req_data_out             = hash.i_hash_data_out;
  assign o_req_rd_en                = {NUM_REQ{hash.i_hash_rd_en}} & gnt_r;
  assign o_req_data_out_valid       = {NUM_REQ{hash.i_hash_data_out_valid}} & gnt_r;
  assign hash.o_hash_start          = start_r;
  assign hash.o_hash_input_length   = in_len_r;
  assign hash.o_hash_output_length  = out_len_r;
  assign hash.o_hash_data_in        = data_in_s;
  assign hash.o_hash_data_out_ready = data_out_ready_s;
  assign hash.o_hash_force_done     = force_done_s;

endmodule

// File: tb/tb_hash_arbiter.sv
// Self-checking bench for hash_arbiter: a scoreboard of expected grants
// and latched lengths is filled as requests are driven and drained on
// every o_hash_start; directed checks cover routing, done and reset.
module tb_hash_arbiter;
  localparam int NR  = 3;
  localparam int IOW = 32;
  localparam int AW  = 10;

  typedef struct {
    logic [NR-1:0] gnt;
    logic [31:0]   il;
    logic [31:0]   ol;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic [NR-1:0]     req, dor, fd;
  logic [NR*32-1:0]  il, ol;
  logic [NR*IOW-1:0] din;
  logic [NR-1:0]     gnt, rd_en, dvalid, done;
  logic [AW-1:0]     addr;
  logic [IOW-1:0]    dout;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  hash_arbiter_if #(.IO_WIDTH(IOW), .ADDR_WIDTH(AW)) hif ();

  hash_arbiter #(.NUM_REQ(NR), .IO_WIDTH(IOW), .ADDR_WIDTH(AW)) dut (
    .i_clk                (clk),
    .i_rst                (rst),
    .i_req                (req),
    .i_req_input_length   (il),
    .i_req_output_length  (ol),
    .i_req_data_in        (din),
    .i_req_data_out_ready (dor),
    .i_req_force_done     (fd),
    .o_gnt                (gnt),
    .o_req_addr           (addr),
    .o_req_rd_en          (rd_en),
    .o_req_data_out       (dout),
    .o_req_data_out_valid (dvalid),
    .o_req_done           (done),
    .hash                 (hif)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input logic [NR-1:0] g, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    e.gnt = g; e.il = a; e.ol = b;
    sb_q.push_back(e);
  endtask

  // Scoreboard: every start pulse must match the next expected job.
  always @(negedge clk) begin
    if (hif.o_hash_start === 1'b1) begin
      if (sb_q.size() == 0) begin
        check_val("sb_unexpected_start", 64'(sb_q.size()), 64'd1);
      end else begin
        mon_e = sb_q.pop_front();
        check_val("sb_gnt", 64'(gnt), 64'(mon_e.gnt));
        check_val("sb_in_len", 64'(hif.o_hash_input_length), 64'(mon_e.il));
        check_val("sb_out_len", 64'(hif.o_hash_output_length), 64'(mon_e.ol));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  task automatic do_reset();
    rst = 1'b1;
    req = '0; fd = '0; dor = '0;
    hif.i_hash_force_done_ack = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Waits (bounded) for the start pulse; returns the negedges elapsed.
  task automatic wait_start(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (hif.o_hash_start !== 1'b1 && cyc < 20);
    if (hif.o_hash_start !== 1'b1) check_val("start_timeout", 64'(hif.o_hash_start), 64'd1);
  endtask

  // Ends requester k's job with force_done + ack; checks the done pulse.
  task automatic finish_job(input int k, input logic [NR-1:0] req_after);
    logic [NR-1:0] m;
    m = 3'b001 << k;
    fd = m;
    hif.i_hash_force_done_ack = 1'b1;
    req = req_after;
    #1;
    check_val("force_done_routed", 64'(hif.o_hash_force_done), 64'd1);
    @(negedge clk);
    check_val("done_pulse", 64'(done), 64'(m));
    check_val("gnt_cleared", 64'(gnt), 64'd0);
    fd = '0;
    hif.i_hash_force_done_ack = 1'b0;
  endtask

  initial begin
    int cyc;
    int k;
    il  = {32'd102, 32'd384, 32'd100};
    ol  = {32'd202, 32'd1024, 32'd200};
    din = {32'h0000_00A2, 32'h0000_00A1, 32'h0000_00A0};
    hif.i_hash_addr           = 10'h155;
    hif.i_hash_rd_en          = 1'b0;
    hif.i_hash_data_out       = 32'h0;
    hif.i_hash_data_out_valid = 1'b0;
    do_reset();

    // Reset state
    check_val("rst_gnt", 64'(gnt), 64'd0);
    check_val("rst_done", 64'(done), 64'd0);
    check_val("rst_start", 64'(hif.o_hash_start), 64'd0);
    check_val("rst_in_len", 64'(hif.o_hash_input_length), 64'd0);
    check_val("rst_out_len", 64'(hif.o_hash_output_length), 64'd0);

    // Single requester 1, lengths 384/1024
    req = 3'b010;
    push_exp(3'b010, 32'd384, 32'd1024);
    wait_start(cyc);
    check_val("single_latency", 64'(cyc), 64'd1);
    @(negedge clk);
    check_val("start_one_cycle", 64'(hif.o_hash_start), 64'd0);
    hif.i_hash_rd_en          = 1'b1;
    hif.i_hash_data_out_valid = 1'b1;
    hif.i_hash_data_out       = 32'hDEAD_BEEF;
    il[63:32] = 32'd999;
    #1;
    check_val("rd_en_gated", 64'(rd_en), 64'h2);
    check_val("valid_gated", 64'(dvalid), 64'h2);
    check_val("data_in_mux", 64'(hif.o_hash_data_in), 64'hA1);
    check_val("data_out_bcast", 64'(dout), 64'hDEAD_BEEF);
    check_val("addr_bcast", 64'(addr), 64'h155);
    @(negedge clk);
    check_val("len_hold", 64'(hif.o_hash_input_length), 64'd384);
    hif.i_hash_rd_en          = 1'b0;
    hif.i_hash_data_out_valid = 1'b0;
    finish_job(1, 3'b000);
    il[63:32] = 32'd384;
    @(negedge clk);
    check_val("done_one_cycle", 64'(done), 64'd0);

    // Spurious ack in IDLE
    hif.i_hash_force_done_ack = 1'b1;
    @(negedge clk);
    hif.i_hash_force_done_ack = 1'b0;
    check_val("idle_ack_gnt", 64'(gnt), 64'd0);
    check_val("idle_ack_done", 64'(done), 64'd0);
    check_val("idle_ack_start", 64'(hif.o_hash_start), 64'd0);

    // Contention: all three held after reset -> 0,1,2,0
    do_reset();
    req = 3'b111;
    push_exp(3'b001, 32'd100, 32'd200);
    push_exp(3'b010, 32'd384, 32'd1024);
    push_exp(3'b100, 32'd102, 32'd202);
    push_exp(3'b001, 32'd100, 32'd200);
    for (int j = 0; j < 4; j++) begin
      k = j % 3;
      wait_start(cyc);
      check_val("rr_gap", 64'(cyc), 64'd1);
      @(negedge clk);
      if (j == 0) begin
        hif.i_hash_force_done_ack = 1'b1;
        @(negedge clk);
        hif.i_hash_force_done_ack = 1'b0;
        check_val("busy_ack_gnt", 64'(gnt), 64'h1);
        check_val("busy_ack_done", 64'(done), 64'd0);
      end
      if (k == 2) begin
        fd  = 3'b001;
        dor = 3'b001;
        hif.i_hash_data_out_valid = 1'b1;
        #1;
        check_val("iso_force_done", 64'(hif.o_hash_force_done), 64'd0);
        check_val("iso_ready", 64'(hif.o_hash_data_out_ready), 64'd0);
        check_val("iso_valid", 64'(dvalid), 64'h4);
        dor = 3'b101;
        #1;
        check_val("iso_ready_own", 64'(hif.o_hash_data_out_ready), 64'd1);
        @(negedge clk);
        check_val("iso_still_busy", 64'(gnt), 64'h4);
        fd  = '0;
        dor = '0;
        hif.i_hash_data_out_valid = 1'b0;
      end
      finish_job(k, (j == 3) ? 3'b000 : 3'b111);
    end
    @(negedge clk);
    check_val("idle_after_drop", 64'(gnt), 64'd0);

    // Reset mid-BUSY abandons the job; requester 0 then wins over 1
    req = 3'b100;
    push_exp(3'b100, 32'd102, 32'd202);
    wait_start(cyc);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_val("midrst_gnt", 64'(gnt), 64'd0);
    check_val("midrst_done", 64'(done), 64'd0);
    check_val("midrst_start", 64'(hif.o_hash_start), 64'd0);
    req = 3'b011;
    push_exp(3'b001, 32'd100, 32'd200);
    push_exp(3'b010, 32'd384, 32'd1024);
    wait_start(cyc);
    check_val("postrst_latency", 64'(cyc), 64'd1);
    @(negedge clk);
    finish_job(0, 3'b010);
    wait_start(cyc);
    @(negedge clk);
    finish_job(1, 3'b000);

    repeat (3) @(negedge clk);
    check_val("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/hash_arbiter.md
HASH_ARBITER -- requirements
Module: hash_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 3, number of hash requesters (2..8).
REQ-002 SHALL have parameter IO_WIDTH, default 32, word width of the hash memory interface.
REQ-003 SHALL have parameter ADDR_WIDTH, default 10, width of the hash read address.
REQ-004 SHALL have port i_clk  in  1  single clock; all logic on rising edge.
REQ-005 SHALL have port i_rst  in  1  synchronous, active-high reset.
REQ-006 SHALL have port i_req  in  NUM_REQ  per-requester level request, held until o_req_done.
REQ-007 SHALL have port i_req_input_length  in  NUM_REQ*32  per-requester hash input length in bits, packed, requester k at [32k+31:32k].
REQ-008 SHALL have port i_req_output_length  in  NUM_REQ*32  per-requester hash output length in bits, packed.
REQ-009 SHALL have port i_req_data_in  in  NUM_REQ*IO_WIDTH  per-requester message word answering o_req_addr.
REQ-010 SHALL have port i_req_data_out_ready  in  NUM_REQ  per-requester output-ready.
REQ-011 SHALL have port i_req_force_done  in  NUM_REQ  per-requester squeeze-terminate request.
REQ-012 SHALL have port o_gnt  out  NUM_REQ  one-hot grant.
REQ-013 SHALL have port o_req_addr  out  ADDR_WIDTH  broadcast read address (copy of i_hash_addr).
REQ-014 SHALL have port o_req_rd_en  out  NUM_REQ  read enable, gated to the granted requester.
REQ-015 SHALL have port o_req_data_out  out  IO_WIDTH  broadcast digest word.
REQ-016 SHALL have port o_req_data_out_valid  out  NUM_REQ  digest valid, gated to the granted requester.
REQ-017 SHALL have port o_req_done  out  NUM_REQ  one-cycle pulse on job completion.
REQ-018 SHALL have hash-side ports o_hash_start, o_hash_input_length[32], o_hash_output_length[32], o_hash_data_in[IO_WIDTH], o_hash_data_out_ready, o_hash_force_done (out) and i_hash_addr[ADDR_WIDTH], i_hash_rd_en, i_hash_data_out[IO_WIDTH], i_hash_data_out_valid, i_hash_force_done_ack (in), connecting 1:1 to hash_mem_interface.

Function
REQ-019 SHALL implement FSM states IDLE, START, BUSY.
REQ-020 IDLE: if any i_req bit is set, SHALL select the winner round-robin, searching from (last_gnt+1) mod NUM_REQ upward; SHALL register o_gnt, latch the winner's input/output lengths, and go to START; otherwise SHALL stay in IDLE.
REQ-021 START: SHALL assert o_hash_start for exactly one cycle, update last_gnt to the winner, and go to BUSY.
REQ-022 Latency: i_req sampled high in IDLE -> o_gnt and o_hash_start high on the next cycle.
REQ-023 o_hash_input_length/o_hash_output_length SHALL hold the latched values from START until the next grant; requester length changes after grant SHALL be ignored.
REQ-024 In START and BUSY: o_hash_data_in SHALL be the granted slice of i_req_data_in (combinational mux); o_req_rd_en[k] = i_hash_rd_en & o_gnt[k]; o_req_data_out_valid[k] = i_hash_data_out_valid & o_gnt[k].
REQ-025 o_hash_data_out_ready and o_hash_force_done SHALL be the granted requester's bits in BUSY only, and 0 in IDLE/START.
REQ-026 BUSY: when o_hash_force_done and i_hash_force_done_ack are both high, SHALL pulse o_req_done[granted] for one cycle, clear o_gnt, and return to IDLE.
REQ-027 i_hash_force_done_ack in IDLE/START, or in BUSY without o_hash_force_done, SHALL be ignored.
REQ-028 Non-granted requesters' force_done/ready SHALL never reach the hash core.
REQ-029 At least one IDLE cycle SHALL separate consecutive grants; a requester still asserting i_req in that cycle is a new request, arbitrated round-robin.
REQ-030 Simultaneous requests SHALL be granted strictly one at a time; no requester SHALL wait more than NUM_REQ-1 jobs.
REQ-031 Requests arriving during START/BUSY SHALL be held pending, not dropped.

Reset
REQ-032 While i_rst is high on a clock edge: state=IDLE, o_gnt=0, o_req_done=0, o_hash_start=0, latched lengths=0, last_gnt=NUM_REQ-1, so requester 0 has first priority.
REQ-033 Reset mid-job SHALL abandon the job without o_req_done; the hash core SHALL share the same reset.

Verification
REQ-034 Single requester: i_req=3'b010, lengths 384/1024 -> next cycle o_gnt=3'b010 with a one-cycle o_hash_start pulse and lengths 384/1024; o_req_done[1] pulses on the force_done/ack cycle.
REQ-035 Contention: i_req=3'b111 held after reset -> grant order 0,1,2,0; exactly one IDLE cycle between jobs.
REQ-036 Isolation: during requester 2's job, requester 0 asserts force_done and ready -> o_hash_force_done and o_hash_data_out_ready follow requester 2 only; o_req_data_out_valid[0]=0 throughout.
REQ-037 Spurious ack: i_hash_force_done_ack pulsed in IDLE and in BUSY without force_done -> no state change and no o_req_done.
REQ-038 Reset mid-BUSY: i_rst for 1 cycle -> o_gnt=0 and IDLE on the next cycle; the next request from requester 1 with requester 0 pending grants requester 0 first.
